// File: rtl/fft_frame_sched.sv
// Run-level sequencer for the streaming FFT: gates the sample source and counts
// input/output frames independently, with completion pulses and a stall watchdog.
module fft_frame_sched #(
  parameter int unsigned DATA_NUM = 8192,
  parameter int unsigned CNT_W    = 13,
  parameter int unsigned FRAME_W  = 16,
  parameter int unsigned TIMEOUT  = 65535,
  parameter int unsigned TO_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [FRAME_W-1:0] num_frames,
  input  logic               abort,
  input  logic               in_valid,
  input  logic               out_valid,
  output logic               src_en,
  output logic               busy,
  output logic               frame_done,
  output logic               run_done,
  output logic               timeout_err,
  output logic [FRAME_W-1:0] frames_out,
  output logic [CNT_W-1:0]   in_cnt,
  output logic [CNT_W-1:0]   out_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_NUM - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE, S_ERR} state_t;

  state_t             state_q, state_d;
  logic               src_en_q, src_en_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               run_done_q, run_done_d;
  logic               timeout_err_q, timeout_err_d;
  logic [FRAME_W-1:0] frames_out_q, frames_out_d;
  logic [FRAME_W-1:0] frames_in_q, frames_in_d;
  logic [FRAME_W-1:0] num_frames_q, num_frames_d;
  logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [TO_W-1:0]    wd_q, wd_d;

  logic in_wrap, out_wrap, last_in, last_out, any_valid, wd_hit;

  always_comb begin
    state_d       = state_q;
    timeout_err_d = timeout_err_q;
    frames_out_d  = frames_out_q;
    frames_in_d   = frames_in_q;
    num_frames_d  = num_frames_q;
    in_cnt_d      = in_cnt_q;
    out_cnt_d     = out_cnt_q;
    wd_d          = wd_q;
    frame_done_d  = 1'b0;
    run_done_d    = 1'b0;
    any_valid     = in_valid | out_valid;
    in_wrap       = (state_q == S_FEED) && in_valid && (in_cnt_q == CNT_LAST);
    out_wrap      = out_valid && (out_cnt_q == CNT_LAST);
    last_in       = in_wrap && (num_frames_q != '0) &&
                    ((frames_in_q + FRAME_W'(1)) == num_frames_q);
    last_out      = out_wrap && (num_frames_q != '0) &&
                    ((frames_out_q + FRAME_W'(1)) == num_frames_q);
    wd_hit        = !any_valid && ((wd_q + TO_W'(1)) == TO_LIMIT);

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          num_frames_d  = num_frames;
          in_cnt_d      = '0;
          out_cnt_d     = '0;
          frames_in_d   = '0;
          frames_out_d  = '0;
          wd_d          = '0;
          timeout_err_d = 1'b0;
          state_d       = S_FEED;
        end
      end
      S_FEED, S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          // Input side only advances while the source is enabled
          if ((state_q == S_FEED) && in_valid) begin
            in_cnt_d = in_wrap ? '0 : in_cnt_q + CNT_W'(1);
            if (in_wrap) frames_in_d = frames_in_q + FRAME_W'(1);
          end
          if (out_valid) begin
            out_cnt_d = out_wrap ? '0 : out_cnt_q + CNT_W'(1);
            if (out_wrap) begin
              frames_out_d = frames_out_q + FRAME_W'(1);
              frame_done_d = 1'b1;
            end
          end
          wd_d = any_valid ? '0 : wd_q + TO_W'(1);
          // Run completion outranks the watchdog and the end-of-feed transition
          if (last_out) begin
            state_d    = S_DONE;
            run_done_d = 1'b1;
          end else if (wd_hit) begin
            state_d       = S_ERR;
            timeout_err_d = 1'b1;
          end else if (last_in) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      S_ERR: begin
        if (abort) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    src_en_d = (state_d == S_FEED);
    busy_d   = (state_d == S_FEED) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      src_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      run_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      frames_out_q  <= '0;
      frames_in_q   <= '0;
      num_frames_q  <= '0;
      in_cnt_q      <= '0;
      out_cnt_q     <= '0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      src_en_q      <= src_en_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      run_done_q    <= run_done_d;
      timeout_err_q <= timeout_err_d;
      frames_out_q  <= frames_out_d;
      frames_in_q   <= frames_in_d;
      num_frames_q  <= num_frames_d;
      in_cnt_q      <= in_cnt_d;
      out_cnt_q     <= out_cnt_d;
      wd_q          <= wd_d;
    end
  end

  assign src_en      = src_en_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign run_done    = run_done_q;
  assign timeout_err = timeout_err_q;
  assign frames_out  = frames_out_q;
  assign in_cnt      = in_cnt_q;
  assign out_cnt     = out_cnt_q;

endmodule

// File: doc/fft_frame_sched.md
Name: fft_frame_sched

Overview:
- Run-level sequencer for the 8192-point streaming FFT pipeline: input sample source, then 13 radix stages, then output.
- On a start command it drives the source enable and counts input samples per frame.
- It counts output samples per frame independently of the input count, so frame N+1 can be fed while frame N drains.
- It reports per-frame and per-run completion, and runs a stall watchdog.

Parameters:
- DATA_NUM, 8192: samples per FFT frame.
- CNT_W, 13: sample counter width; must satisfy 2^CNT_W >= DATA_NUM.
- FRAME_W, 16: frame counter and run-length width.
- TIMEOUT, 65535: stall limit in busy cycles with neither in_valid nor out_valid.
- TO_W, 16: watchdog counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request; sampled only in IDLE.
- num_frames  in  FRAME_W  frames in this run, latched on start; 0 = continuous until abort.
- abort  in  1  terminate the run.
- in_valid  in  1  source data-valid (FFT input valid).
- out_valid  in  1  last-stage output valid.
- src_en  out  1  source enable, registered.
- busy  out  1  high in FEED and DRAIN.
- frame_done  out  1  one-cycle pulse on the DATA_NUM-th out_valid of a frame.
- run_done  out  1  one-cycle pulse when a run completes.
- timeout_err  out  1  sticky watchdog error.
- frames_out  out  FRAME_W  frames completed in the current run.
- in_cnt  out  CNT_W  input samples of the current input frame.
- out_cnt  out  CNT_W  output samples of the current output frame.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; all outputs 0; all counters 0; latched num_frames=0.
- States: IDLE, FEED, DRAIN, DONE, ERR. All outputs are registered.
- IDLE:
  - start=1 and abort=0: latch num_frames; clear in_cnt, out_cnt, frames_in, frames_out, watchdog and timeout_err; go to FEED.
  - src_en and busy rise in the cycle after start is accepted.
- FEED (src_en=1):
  - Each in_valid increments in_cnt. At in_cnt==DATA_NUM-1 together with in_valid: in_cnt wraps to 0 and frames_in increments.
  - If frames_in+1==num_frames (num_frames!=0), go to DRAIN; src_en is 0 from the next cycle.
- DRAIN (src_en=0): in_valid is ignored and not counted.
- out_valid counting (FEED and DRAIN):
  - Each out_valid increments out_cnt.
  - At out_cnt==DATA_NUM-1 together with out_valid: out_cnt wraps to 0, frames_out increments, frame_done pulses the next cycle.
- Run completion: when frames_out reaches num_frames (num_frames!=0), go to DONE. DONE lasts one cycle with run_done=1 and busy=0, then IDLE.
- Frame counters: with num_frames=0, frames_in and frames_out wrap modulo 2^FRAME_W.
- Simultaneous events:
  - In-frame and out-frame completion in the same cycle are both counted.
  - Last input and an out-frame completion in the same cycle: both are processed.
  - out_valid completing the final frame while still in FEED is impossible by pipeline order; if it occurs, DONE takes priority.
- Watchdog:
  - Counts while busy and in_valid=0 and out_valid=0; clears on either valid.
  - On reaching TIMEOUT: go to ERR with src_en=0 and timeout_err=1.
  - ERR holds until abort (then IDLE). timeout_err stays set until the next accepted start.
- abort:
  - From any state except IDLE: next cycle state=IDLE, src_en=0, busy=0.
  - Counters are held for readback; no run_done pulse.
  - abort and start in the same cycle: abort wins, start is ignored.
- start while not IDLE: ignored.
- rst_n asserted mid-run: immediate return to reset values; src_en drops asynchronously.
- out_valid in IDLE: ignored.

Test Plan:
- num_frames=1, source gives 8192 contiguous in_valid, pipeline gives 8192 out_valid later -> src_en high for exactly 8192 valid cycles; one frame_done; run_done one cycle after the 8192nd out_valid is registered; frames_out=1.
- num_frames=3 with overlapped feeding (frame 2 input while frame 1 output) -> in_cnt and out_cnt wrap independently; three frame_done pulses; frames_out=3; single run_done.
- num_frames=0, 5 frames, then abort -> no run_done; frames_out=5; src_en=0 and busy=0 the cycle after abort.
- Stall injected mid-FEED with TIMEOUT=16 -> timeout_err=1 after 16 idle cycles; src_en=0; held in ERR until abort; next start clears timeout_err.
- start and abort asserted together in IDLE -> remains IDLE; start while busy -> no effect on counters.
- rst_n pulled low at in_cnt=4000 -> all outputs 0 immediately; next start begins with in_cnt=0.
